// File: rtl/ram_req_sched.sv
// Request scheduler for a dual-read/single-write RAM: buffered writes, two latency-2 read channels.
// Define RAM_REQ_SCHED_WR_FWD_EN to forward buffered write data instead of stalling hazarding reads.
module ram_req_sched #(
   parameter int unsigned WBUF_DEPTH = 4,
   parameter int unsigned AW         = 18,
   parameter int unsigned DW         = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_req_valid,
   output logic                        wr_req_ready,
   input  logic [AW-1:0]               wr_req_addr,
   input  logic [DW-1:0]               wr_req_data,
   input  logic                        rd_a_valid,
   output logic                        rd_a_ready,
   input  logic [AW-1:0]               rd_a_addr,
   output logic                        rd_a_rsp_valid,
   output logic [DW-1:0]               rd_a_rsp_data,
   input  logic                        rd_b_valid,
   output logic                        rd_b_ready,
   input  logic [AW-1:0]               rd_b_addr,
   output logic                        rd_b_rsp_valid,
   output logic [DW-1:0]               rd_b_rsp_data,
   input  logic                        ram_hold,
   output logic                        ram_wr,
   output logic [AW-1:0]               ram_wr_addr,
   output logic [DW-1:0]               ram_d_in,
   output logic [AW-1:0]               ram_rd_addr_a,
   output logic [AW-1:0]               ram_rd_addr_b,
   input  logic [DW-1:0]               ram_d_out_a,
   input  logic [DW-1:0]               ram_d_out_b,
   output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);
   localparam int unsigned PW = $clog2(WBUF_DEPTH);

   logic [AW-1:0]         mem_addr [WBUF_DEPTH];
   logic [DW-1:0]         mem_data [WBUF_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [PW:0]           count_q, count_d;
   logic                  full, push, pop;
   logic [WBUF_DEPTH-1:0] ent_valid;

   assign full         = (count_q == (PW+1)'(WBUF_DEPTH));
   assign wr_req_ready = !reset && !full;
   assign push         = wr_req_valid && wr_req_ready;
   assign ram_wr       = !reset && (count_q != '0) && !ram_hold;
   assign pop          = ram_wr;
   assign ram_wr_addr  = reset ? '0 : mem_addr[rd_ptr_q];
   assign ram_d_in     = reset ? '0 : mem_data[rd_ptr_q];
   assign wbuf_count   = count_q;
   assign count_d      = count_q + (PW+1)'(push) - (PW+1)'(pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr_q] <= wr_req_addr;
         mem_data[wr_ptr_q] <= wr_req_data;
      end
   end

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         ent_valid[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      end
   end

   logic [AW-1:0] rd_addr [2];
   logic [1:0]    rd_valid, rd_ready, hazard, accept;

   assign rd_addr[0] = rd_a_addr;
   assign rd_addr[1] = rd_b_addr;
   assign rd_valid   = {rd_b_valid, rd_a_valid};
   assign accept     = rd_valid & rd_ready;
   assign rd_a_ready = rd_ready[0];
   assign rd_b_ready = rd_ready[1];

   // The head being popped still counts: the RAM only commits it at this edge.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         hazard[c] = push && (wr_req_addr == rd_addr[c]);
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (ent_valid[i] && (mem_addr[i] == rd_addr[c])) hazard[c] = 1'b1;
         end
      end
   end

   logic [DW-1:0] rsp_src [2];

`ifdef RAM_REQ_SCHED_WR_FWD_EN
   logic [DW-1:0] fwd_data [2];
   logic [DW-1:0] fwd_q    [2];
   logic [1:0]    fwd_hit_q;

   // Scan oldest to youngest so the last match wins; an incoming write beats all.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         fwd_data[c] = '0;
         for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (((PW+1)'(k) < count_q) && (mem_addr[rd_ptr_q + PW'(k)] == rd_addr[c])) begin
               fwd_data[c] = mem_data[rd_ptr_q + PW'(k)];
            end
         end
         if (push && (wr_req_addr == rd_addr[c])) fwd_data[c] = wr_req_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_hit_q <= '0;
         for (int c = 0; c < 2; c++) fwd_q[c] <= '0;
      end else begin
         fwd_hit_q <= accept & hazard;
         for (int c = 0; c < 2; c++) begin
            if (accept[c]) fwd_q[c] <= fwd_data[c];
         end
      end
   end
`endif

   always_comb begin
      rsp_src[0] = ram_d_out_a;
      rsp_src[1] = ram_d_out_b;
`ifdef RAM_REQ_SCHED_WR_FWD_EN
      rd_ready = reset ? 2'b00 : 2'b11;
      for (int c = 0; c < 2; c++) begin
         if (fwd_hit_q[c]) rsp_src[c] = fwd_q[c];
      end
`else
      rd_ready = reset ? 2'b00 : ~hazard;
`endif
   end

   logic [1:0]    stage_q, rsp_valid_q;
   logic [AW-1:0] rd_addr_q  [2];
   logic [DW-1:0] rsp_data_q [2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q     <= '0;
         rsp_valid_q <= '0;
         for (int c = 0; c < 2; c++) begin
            rd_addr_q[c]  <= '0;
            rsp_data_q[c] <= '0;
         end
      end else begin
         stage_q     <= accept;
         rsp_valid_q <= stage_q;
         for (int c = 0; c < 2; c++) begin
            if (accept[c])  rd_addr_q[c]  <= rd_addr[c];
            if (stage_q[c]) rsp_data_q[c] <= rsp_src[c];
         end
      end
   end

   assign ram_rd_addr_a  = rd_addr_q[0];
   assign ram_rd_addr_b  = rd_addr_q[1];
   assign rd_a_rsp_valid = rsp_valid_q[0];
   assign rd_b_rsp_valid = rsp_valid_q[1];
   assign rd_a_rsp_data  = rsp_data_q[0];
   assign rd_b_rsp_data  = rsp_data_q[1];

endmodule
